// File: rtl/dec_seq_pkg.sv
// Shared types and constants for the sequenced shifter.
package dec_seq_pkg;

    // FSM encoding; the unused code 2'd3 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Shift direction as seen by dec_LR.
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Width needed for the distance/counter fields so that the value WAY fits.
    function automatic int cnt_width(input int way);
        return $clog2(way) + 1;
    endfunction

endpackage

// File: rtl/dec_seq_if.sv
// Controller-side bundle for dec_seq: request fields plus status/result.
interface dec_seq_if
    import dec_seq_pkg::*;
#(
    parameter int WAY   = 8,
    parameter int CNT_W = cnt_width(WAY)
);
    logic             start;
    logic [WAY-1:0]   a;
    logic             lr;
    logic [CNT_W-1:0] n;
    logic [WAY-1:0]   s;
    logic             busy;
    logic             done;

    modport master (
        output start, a, lr, n,
        input  s, busy, done
    );

    modport slave (
        input  start, a, lr, n,
        output s, busy, done
    );
endinterface

// File: rtl/dec_seq_lr.sv
// Single-position zero-fill shifter: lr=0 shifts toward MSB, lr=1 toward LSB.
module dec_LR #(
    parameter int WAY = 8
) (
    input  logic [WAY-1:0] a,
    input  logic           lr,
    output logic [WAY-1:0] s
);
    assign s = lr ? (a >> 1) : (a << 1);
endmodule

// File: rtl/dec_seq.sv
// Multi-cycle shifter: moves a captured word one position per clock until the
// requested (clamped) distance is exhausted, then pulses done for one cycle.
module dec_seq
    import dec_seq_pkg::*;
#(
    parameter int WAY   = 8,
    parameter int CNT_W = cnt_width(WAY)
) (
    input  logic      clk,
    input  logic      reset,
    dec_seq_if.slave  bus
);
    localparam logic [CNT_W-1:0] WAY_C = CNT_W'(WAY);

    state_t           state;
    logic [WAY-1:0]   s_q;
    logic [WAY-1:0]   s_step;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k;
    logic             dir;
    logic             busy_q;
    logic             done_q;

    // Distances beyond the word width all produce zero, so cap at WAY steps.
    assign k = (bus.n > WAY_C) ? WAY_C : bus.n;

    dec_LR #(.WAY(WAY)) u_step (
        .a  (s_q),
        .lr (dir),
        .s  (s_step)
    );

    // Sequencer: capture on start, step once per cycle, flag completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            s_q    <= '0;
            cnt    <= '0;
            dir    <= LEFT;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        s_q <= bus.a;
                        dir <= bus.lr;
                        cnt <= k;
                        if (k != '0) begin
                            state  <= SHIFT;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    s_q <= s_step;
                    cnt <= cnt - 1'b1;
                    // cnt can never be zero here; treat it as the last step anyway.
                    if (cnt <= CNT_W'(1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s    = s_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_dec_seq.sv
// Directed bench for dec_seq (WAY=8): vector table plus multi-cycle sequences.
module tb_dec_seq;
    localparam int WAY   = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dec_seq_if #(.WAY(WAY), .CNT_W(CNT_W)) bus ();

    dec_seq #(.WAY(WAY), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WAY-1:0]   a;
        logic             lr;
        logic [CNT_W-1:0] n;
        logic [WAY-1:0]   exp_s;
        int               exp_k;
        bit               scramble;
        bit               poke;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One transaction: start for one edge, watch busy/done, verify result.
    task automatic run(input vec_t v, input string tag);
        int ticks;
        int busycnt;
        int overlap;
        logic [WAY-1:0] a_orig;
        a_orig    = v.a;
        bus.start = 1'b1;
        bus.a     = v.a;
        bus.lr    = v.lr;
        bus.n     = v.n;
        tick();
        bus.start = 1'b0;
        if (v.scramble) begin
            bus.a  = 8'hFF;
            bus.lr = 1'b0;
            bus.n  = 4'd9;
        end
        ticks   = 1;
        busycnt = 0;
        overlap = 0;
        while (!bus.done && ticks < 40) begin
            if (bus.busy) busycnt++;
            if (v.poke && busycnt == 3) bus.start = 1'b1;
            else bus.start = 1'b0;
            tick();
            ticks++;
        end
        bus.start = 1'b0;
        if (bus.busy && bus.done) overlap = 1;
        check({tag, "_done_seen"}, int'(bus.done), 1);
        check({tag, "_latency"}, ticks, v.exp_k + 1);
        check({tag, "_busy_cycles"}, busycnt, v.exp_k);
        check({tag, "_result"}, int'(bus.s), int'(v.exp_s));
        check({tag, "_busy_done_overlap"}, overlap, 0);
        // done must drop, nothing must restart, result must hold.
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_quiet_done"}, int'(bus.done), 0);
            check({tag, "_quiet_busy"}, int'(bus.busy), 0);
        end
        check({tag, "_hold"}, int'(bus.s), int'(v.exp_s));
        if (a_orig == 8'h00) check({tag, "_unused"}, 0, 0);
    endtask

    initial begin
        int prev_busy;
        int last_acc;
        int n_acc;
        int n_done;
        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.lr    = 1'b0;
        bus.n     = '0;
        reset     = 1'b1;

        vecs[0] = '{8'h10, 1'b0, 4'd1,  8'h20, 1, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 1'b1, 4'd2,  8'h04, 2, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 4'd0,  8'hA5, 0, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 4'd9,  8'h00, 8, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b0, 4'd3,  8'h08, 3, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 4'd1,  8'h40, 1, 1'b0, 1'b0};
        vecs[6] = '{8'h81, 1'b0, 4'd4,  8'h10, 4, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 4'd7,  8'h01, 7, 1'b0, 1'b0};
        vecs[8] = '{8'h3C, 1'b1, 4'd8,  8'h00, 8, 1'b0, 1'b0};
        vecs[9] = '{8'hC3, 1'b0, 4'd15, 8'h00, 8, 1'b0, 1'b0};

        tick();
        tick();
        tick();
        check("reset_s", int'(bus.s), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        reset = 1'b0;
        tick();
        check("idle_s", int'(bus.s), 0);

        for (int i = 0; i < 10; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the third SHIFT cycle discards the transaction.
        bus.start = 1'b1;
        bus.a     = 8'h81;
        bus.lr    = 1'b1;
        bus.n     = 4'd5;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("midrst_busy_before", int'(bus.busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_s", int'(bus.s), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done || bus.busy) n_done++;
        end
        check("midrst_no_activity", n_done, 0);
        run('{8'h01, 1'b0, 4'd3, 8'h08, 3, 1'b0, 1'b0}, "after_rst");

        // start held high: accepted every k+2 = 3 edges, each result 2.
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.lr    = 1'b0;
        bus.n     = 4'd1;
        prev_busy = 0;
        last_acc  = -1;
        n_acc     = 0;
        n_done    = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus.busy && prev_busy == 0) begin
                if (last_acc >= 0) check("b2b_spacing", t - last_acc, 3);
                last_acc = t;
                n_acc++;
            end
            if (bus.done) begin
                n_done++;
                check("b2b_result", int'(bus.s), 2);
            end
            prev_busy = int'(bus.busy);
        end
        bus.start = 1'b0;
        check("b2b_accepts", n_acc, 4);
        check("b2b_dones", n_done, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
